// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types and constants for the core pipeline control blocks
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    typedef logic [4:0] regIdx_t;

    localparam regIdx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector, shared with forwarding
import core_ctrl_pkg::*;

module load_use_detect (
    input  regIdx_t idRs1,
    input  regIdx_t idRs2,
    input  logic    idUsesRs1,
    input  logic    idUsesRs2,
    input  regIdx_t exRd,
    input  logic    exMemRead,
    output logic    luh
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = idUsesRs1 && (idRs1 == exRd);
    assign rs2_hit = idUsesRs2 && (idRs2 == exRd);

    // x0 is hardwired zero, so a load targeting it never produces a usable value
    assign luh = exMemRead && (exRd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - pipeline stall/bubble/flush control with memory-wait timeout
import core_ctrl_pkg::*;

module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  regIdx_t          idRs1,
    input  regIdx_t          idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  regIdx_t          exRd,
    input  logic             exMemRead,
    input  logic             branchTaken,
    input  logic             dmemReq,
    input  logic             dmemAck,
    output logic             selOp,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExWrite,
    output logic             exMemWrite,
    output logic             flushIfId,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount
);

    state_e            state_q, state_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              luh;
    logic              mst;

    load_use_detect u_luh (
        .idRs1     (idRs1),
        .idRs2     (idRs2),
        .idUsesRs1 (idUsesRs1),
        .idUsesRs2 (idUsesRs2),
        .exRd      (exRd),
        .exMemRead (exMemRead),
        .luh       (luh)
    );

    assign mst = dmemReq && !dmemAck;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        selOp      = 1'b0;
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        flushIfId  = 1'b0;
        memTimeout = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                if ((state_q == RUN && mst) || (state_q == MEM_WAIT && !dmemAck)) begin
                    pcWrite    = 1'b0;
                    ifIdWrite  = 1'b0;
                    idExWrite  = 1'b0;
                    exMemWrite = 1'b0;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        tmo_d   = 8'd1;
                    end else if (tmo_q == 8'(MEM_TIMEOUT)) begin
                        state_d = ERROR;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    // Ack (or no access): resolve branch/load-use as a normal RUN cycle
                    state_d = RUN;
                    tmo_d   = 8'd0;
                    if (branchTaken) begin
                        flushIfId = 1'b1;
                        selOp     = 1'b1;
                    end else if (luh) begin
                        pcWrite   = 1'b0;
                        ifIdWrite = 1'b0;
                        selOp     = 1'b1;
                    end
                end
            end
            ERROR: begin
                memTimeout = 1'b1;
                selOp      = 1'b1;
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExWrite  = 1'b0;
                exMemWrite = 1'b0;
            end
            default: begin
                state_d = RUN;
                tmo_d   = 8'd0;
            end
        endcase

        if (!resetN) begin
            selOp      = 1'b1;
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            flushIfId  = 1'b0;
            memTimeout = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pcWrite && !(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= RUN;
            tmo_q   <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    assign stallCount = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed self-checking bench for hazard_stall_unit
`timescale 1ns/1ps
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        idUsesRs1, idUsesRs2, exMemRead, branchTaken, dmemReq, dmemAck;
    logic        selOp, pcWrite, ifIdWrite, idExWrite, exMemWrite, flushIfId, memTimeout;
    logic [31:0] stallCount;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sc   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .idRs1       (idRs1),
        .idRs2       (idRs2),
        .idUsesRs1   (idUsesRs1),
        .idUsesRs2   (idUsesRs2),
        .exRd        (exRd),
        .exMemRead   (exMemRead),
        .branchTaken (branchTaken),
        .dmemReq     (dmemReq),
        .dmemAck     (dmemAck),
        .selOp       (selOp),
        .pcWrite     (pcWrite),
        .ifIdWrite   (ifIdWrite),
        .idExWrite   (idExWrite),
        .exMemWrite  (exMemWrite),
        .flushIfId   (flushIfId),
        .memTimeout  (memTimeout),
        .stallCount  (stallCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // {selOp, pcWrite, ifIdWrite, idExWrite, exMemWrite, flushIfId, memTimeout}
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, selOp, pcWrite, ifIdWrite, idExWrite, exMemWrite, flushIfId, memTimeout},
              {25'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        exRd = 0; exMemRead = 0; branchTaken = 0; dmemReq = 0; dmemAck = 0;
    endtask

    initial begin
        resetN = 1'b0;
        idle();
        #12;
        check_ctl("reset_outputs", 7'b1000000);
        check("reset_stallcount", stallCount, 0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        check_ctl("idle_run", 7'b0111100);

        // Load-use on rs1: one bubble, then clear
        cyc();
        exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        #1 check_ctl("luh_rs1", 7'b1001100);
        cyc(); exp_sc++;
        exMemRead = 0;
        #1 check_ctl("luh_cleared", 7'b0111100);
        check("luh_stallcount", stallCount, exp_sc);

        // Load-use on rs2 only
        idle(); exMemRead = 1; exRd = 7; idRs2 = 7; idUsesRs2 = 1; idRs1 = 3; idUsesRs1 = 1;
        #1 check_ctl("luh_rs2", 7'b1001100);
        cyc(); exp_sc++;

        // Matching rs1 but not used -> no stall
        idle(); exMemRead = 1; exRd = 9; idRs1 = 9; idUsesRs1 = 0;
        #1 check_ctl("luh_unused_rs", 7'b0111100);

        // exRd = x0 never stalls
        idle(); exMemRead = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
        #1 check_ctl("luh_x0", 7'b0111100);
        cyc();
        check("x0_stallcount", stallCount, exp_sc);

        // Branch overrides load-use
        idle(); exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1; branchTaken = 1;
        #1 check_ctl("branch_over_luh", 7'b1111110);
        cyc();
        idle();
        #1 check("branch_stallcount", stallCount, exp_sc);

        // Memory wait: 3 stall cycles then ack
        dmemReq = 1;
        #1 check_ctl("mst_run", 7'b0000000);
        cyc(); exp_sc++;
        check_ctl("mst_wait1", 7'b0000000);
        cyc(); exp_sc++;
        check_ctl("mst_wait2", 7'b0000000);
        cyc(); exp_sc++;
        dmemAck = 1;
        #1 check_ctl("mst_ack", 7'b0111100);
        cyc();
        idle();
        #1 check_ctl("mst_back_run", 7'b0111100);
        check("mst_stallcount", stallCount, exp_sc);

        // Memory stall beats branch; branch resolves on ack
        dmemReq = 1; branchTaken = 1;
        #1 check_ctl("mst_over_branch", 7'b0000000);
        cyc(); exp_sc++;
        dmemAck = 1;
        #1 check_ctl("branch_after_ack", 7'b1111110);
        cyc();

        // Memory stall beats load-use; bubble inserted only after ack
        idle(); dmemReq = 1; exMemRead = 1; exRd = 4; idRs2 = 4; idUsesRs2 = 1;
        #1 check_ctl("mst_over_luh", 7'b0000000);
        cyc(); exp_sc++;
        dmemAck = 1;
        #1 check_ctl("luh_after_ack", 7'b1001100);
        cyc(); exp_sc++;
        idle();
        #1 check("combo_stallcount", stallCount, exp_sc);

        // Timeout: RUN stall cycle, then 16 MEM_WAIT cycles, then ERROR
        dmemReq = 1;
        cyc(); exp_sc++;
        for (int i = 0; i < 15; i++) begin
            cyc(); exp_sc++;
        end
        check_ctl("wait16_not_error", 7'b0000000);
        cyc(); exp_sc++;
        check_ctl("timeout_error", 7'b1000001);
        dmemAck = 1; dmemReq = 0;
        cyc(); exp_sc++;
        check_ctl("error_ignores_ack", 7'b1000001);
        check("error_stallcount", stallCount, exp_sc);
        resetN = 1'b0;
        #1 check_ctl("error_reset", 7'b1000000);
        check("error_reset_stallcount", stallCount, 0);
        idle();
        #2 resetN = 1'b1;
        #1 check_ctl("post_error_run", 7'b0111100);

        // Asynchronous reset in the middle of MEM_WAIT
        cyc();
        dmemReq = 1;
        cyc();
        cyc();
        #2 resetN = 1'b0;
        #1 check_ctl("async_reset_outputs", 7'b1000000);
        check("async_reset_stallcount", stallCount, 0);
        idle();
        #1 resetN = 1'b1;
        cyc();
        check_ctl("after_async_reset", 7'b0111100);
        check("after_async_stallcount", stallCount, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard and stall controller for the RISC-V core.
- Generates the bubble-select driven into the control-signal bubble mux between ID and EX, plus pipeline-register write enables and the IF/ID flush.
- Handles load-use hazards, taken-branch flushes and multi-cycle data-memory waits (req/ack handshake), with a memory-timeout error state and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before error; legal range 2..255.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous reset, active low.
- idRs1  in  5  rs1 of the instruction in ID.
- idRs2  in  5  rs2 of the instruction in ID.
- idUsesRs1  in  1  ID instruction reads rs1.
- idUsesRs2  in  1  ID instruction reads rs2.
- exRd  in  5  destination register of the instruction in EX.
- exMemRead  in  1  EX instruction is a load.
- branchTaken  in  1  EX resolved a taken branch or jump.
- dmemReq  in  1  MEM stage is accessing data memory this cycle.
- dmemAck  in  1  data memory completes the access this cycle.
- selOp  out  1  1 = force ID control signals to zero (bubble).
- pcWrite  out  1  PC register enable.
- ifIdWrite  out  1  IF/ID register enable.
- idExWrite  out  1  ID/EX register enable.
- exMemWrite  out  1  EX/MEM and MEM/WB register enable.
- flushIfId  out  1  clear IF/ID to NOP on the next edge.
- memTimeout  out  1  sticky error flag.
- stallCount  out  CNT_W  cycles in which pcWrite was 0 while not in reset.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Outputs are combinational from the current state and inputs. State, timeout counter and stallCount are registered.
- While resetN is low:
  - selOp=1, flushIfId=0.
  - pcWrite, ifIdWrite, idExWrite and exMemWrite are all 0.
  - memTimeout=0, stallCount=0, timeout counter=0.
  - Reset mid-operation (any state) returns to RUN with these values.
- Load-use hazard (luh) = exMemRead && exRd!=0 && ((idUsesRs1 && idRs1==exRd) || (idUsesRs2 && idRs2==exRd)).
- Memory stall (mst) = dmemReq && !dmemAck.
- RUN, priority order:
  1. mst: all write enables 0, selOp=0, flushIfId=0. Next state MEM_WAIT, timeout counter := 1.
  2. branchTaken: pcWrite, ifIdWrite, idExWrite and exMemWrite all 1; flushIfId=1; selOp=1, so the wrong-path ID instruction becomes a bubble. branchTaken overrides luh.
  3. luh: pcWrite=0, ifIdWrite=0, selOp=1, idExWrite=1, exMemWrite=1. This inserts exactly one bubble; the next cycle exMemRead is 0, so the hazard clears.
  4. Otherwise all write enables 1, selOp=0, flushIfId=0.
- MEM_WAIT:
  - While !dmemAck: all write enables 0, selOp=0, flushIfId=0; timeout counter increments.
  - When dmemAck=1: evaluate as RUN without mst (branch, load-use or normal) and return to RUN.
  - When the counter equals MEM_TIMEOUT and ack is still 0: next state ERROR.
- ERROR:
  - memTimeout=1, all write enables 0, selOp=1.
  - Only reset exits ERROR. dmemAck is ignored.
- stallCount:
  - Increments on each edge where pcWrite==0 and resetN is high.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - mst with branchTaken: stall wins; the branch is re-evaluated when ack arrives, because EX is frozen and branchTaken stays asserted.
  - luh with mst: stall wins; no bubble is inserted during the wait.
- exRd==0 never causes a load-use stall.

Decomposition:
- Package core_ctrl_pkg holds:
  - the typedef enum for the states: RUN, MEM_WAIT, ERROR (2 bits);
  - constant REG_ZERO=5'd0;
  - the register-index typedef regIdx_t (5 bits).
- Sub-module load_use_detect is purely combinational: inputs are the idRs/idUses/exRd/exMemRead signals, output is luh. It is reusable by the forwarding unit.
- FSM, timeout counter and perf counter stay in the top module.

Test Plan:
- Load-use: exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1.
  -> Cycle 0: selOp=1, pcWrite=0, ifIdWrite=0, idExWrite=1. Next cycle, with exMemRead=0: all enables 1. stallCount=1.
- Load with exRd=0 and idRs1=0.
  -> No stall; selOp=0, pcWrite=1.
- branchTaken=1 together with a load-use match.
  -> flushIfId=1, selOp=1, pcWrite=1; no stall. stallCount unchanged.
- dmemReq=1 with dmemAck=0 for 3 cycles, then ack.
  -> Enables 0 for 3 cycles; RUN again in the ack cycle with enables 1. stallCount=3.
- dmemReq=1, never acked, MEM_TIMEOUT=16.
  -> ERROR after 16 wait cycles: memTimeout=1, selOp=1, enables 0. Holds until resetN pulses low, then memTimeout=0 and state is RUN.
- Assert resetN low in the middle of MEM_WAIT.
  -> Outputs take their reset values immediately (asynchronously). After release: state RUN, stallCount=0.
